reflet_bus_arbiter: RTL and testbench

Two-master arbiter for the 8-bit microcontroller system bus. It sits between the CPU and the shared memory/peripheral bus (instruction RAM, data RAM, peripheral block) and lets a secondary master (loader, DMA, debug port) borrow the bus. While the secondary master owns the bus, the CPU is frozen through its `enable` input. Burst-length and CPU-minimum-share limits keep the CPU from being starved.

---
 rtl/reflet_bus_pkg.sv | 22 ++
 rtl/reflet_sat_counter.sv | 43 ++++
 rtl/reflet_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_reflet_bus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_bus_pkg.sv
// Shared definitions for the two-master system bus arbiter: the ownership
// states, default limits and the width helper for the small counters.
package reflet_bus_pkg;

    // Who owns the shared bus. PARK and RETURN are single-cycle buffers
    // around a DMA grant.
    typedef enum logic [1:0] {
        S_CPU_OWN = 2'd0,
        S_PARK    = 2'd1,
        S_DMA_OWN = 2'd2,
        S_RETURN  = 2'd3
    } bus_state_e;

    localparam int DEFAULT_MAX_BURST = 16;
    localparam int DEFAULT_CPU_MIN   = 4;

    // Bits needed for a counter that must be able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reflet_sat_counter.sv
// Up-counter with synchronous clear that stops at MAX. Clear wins over
// increment. The reset value is a parameter so a counter can start "full".
module reflet_sat_counter
    import reflet_bus_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W = cnt_width(MAX),
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, else step until the ceiling is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reflet_bus_arbiter.sv
// Two-master arbiter for the 8-bit system bus. The CPU owns the bus by
// default; a secondary master (loader/DMA/debug) borrows it for bounded
// bursts while the CPU is frozen through cpu_enable.
//
// Handshake: the secondary master holds dma_req high while it wants the bus.
// A transfer happens in every cycle where dma_grant and dma_req are both
// high; its address/data/write_en are taken in that same cycle. The master
// must keep dma_req (and the first transfer's fields) stable until it sees
// dma_grant, since requests outside DMA_OWN are not queued. Read data comes
// back one cycle after the transfer, marked by dma_rvalid.
module reflet_bus_arbiter
    import reflet_bus_pkg::*;
#(
    parameter int wordsize  = 8,
    parameter int max_burst = DEFAULT_MAX_BURST,
    parameter int cpu_min   = DEFAULT_CPU_MIN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_data_out,
    input  logic                cpu_write_en,
    output logic                cpu_enable,
    input  logic                dma_req,
    input  logic [wordsize-1:0] dma_addr,
    input  logic [wordsize-1:0] dma_wdata,
    input  logic                dma_write_en,
    output logic                dma_grant,
    output logic                dma_rvalid,
    output logic [wordsize-1:0] dma_rdata,
    output logic [wordsize-1:0] bus_addr,
    output logic [wordsize-1:0] bus_data_out,
    output logic                bus_write_en,
    input  logic [wordsize-1:0] bus_data_in,
    output logic [1:0]          dbg_state
);

    localparam logic [1:0] CPU_OWN = S_CPU_OWN;
    localparam logic [1:0] PARK    = S_PARK;
    localparam logic [1:0] DMA_OWN = S_DMA_OWN;
    localparam logic [1:0] RETURN  = S_RETURN;

    localparam int CW = cnt_width(cpu_min);
    localparam int BW = cnt_width(max_burst);

    localparam logic [CW-1:0] CPU_QUOTA  = CW'(cpu_min);
    localparam logic [BW-1:0] BURST_LAST = BW'(max_burst - 1);

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [CW-1:0]       cpu_cnt;
    logic [BW-1:0]       burst_cnt;
    logic                dma_xfer;
    logic                dma_read;
    logic                dma_rvalid_q;
    logic [wordsize-1:0] dma_rdata_q;

    assign dma_xfer = (state_q == DMA_OWN) && dma_req;
    assign dma_read = dma_xfer && !dma_write_en;

    // CPU share since the last burst; starts full so the first request
    // after reset is served at once.
    reflet_sat_counter #(
        .MAX     (cpu_min),
        .W       (CW),
        .RST_VAL (CPU_QUOTA)
    ) u_cpu_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (state_q == RETURN),
        .inc_i  (state_q == CPU_OWN),
        .cnt_o  (cpu_cnt)
    );

    // Transfers in the current grant; cleared in PARK so it is zero on entry.
    reflet_sat_counter #(
        .MAX     (max_burst),
        .W       (BW),
        .RST_VAL ('0)
    ) u_burst_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (state_q == PARK),
        .inc_i  (dma_xfer),
        .cnt_o  (burst_cnt)
    );

    // Ownership sequencing: CPU -> PARK -> DMA -> RETURN -> CPU.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_OWN: begin
                if (dma_req && (cpu_cnt == CPU_QUOTA)) begin
                    state_d = PARK;
                end
            end
            PARK: begin
                state_d = DMA_OWN;
            end
            DMA_OWN: begin
                if (!dma_req || (burst_cnt == BURST_LAST)) begin
                    state_d = RETURN;
                end
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    // State register; reset hands the bus straight back to the CPU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CPU_OWN;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus mux. PARK keeps the CPU address but blocks any CPU write that was
    // in flight; RETURN drives no write.
    always_comb begin
        bus_addr     = cpu_addr;
        bus_data_out = cpu_data_out;
        bus_write_en = 1'b0;
        case (state_q)
            CPU_OWN: begin
                bus_write_en = cpu_write_en;
            end
            PARK: begin
                bus_data_out = '0;
            end
            DMA_OWN: begin
                bus_addr     = dma_addr;
                bus_data_out = dma_wdata;
                bus_write_en = dma_write_en & dma_req;
            end
            default: begin
                bus_write_en = 1'b0;
            end
        endcase
    end

    // Read return path: capture the slave data one cycle after a DMA read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            dma_rvalid_q <= dma_read;
            if (dma_read) begin
                dma_rdata_q <= bus_data_in;
            end
        end
    end

    assign cpu_enable = (state_q == CPU_OWN);
    assign dma_grant  = (state_q == DMA_OWN);
    assign dma_rvalid = dma_rvalid_q;
    assign dma_rdata  = dma_rdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Bench for reflet_bus_arbiter: per-cycle expected bus view from a
// count-based reference model, read-data scoreboard, directed scenarios
// followed by random traffic.
module tb_reflet_bus_arbiter;

  localparam int W    = 8;
  localparam int MAXB = 4;
  localparam int CMIN = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] cpu_addr     = '0;
  logic [W-1:0] cpu_data_out = '0;
  logic         cpu_write_en = 1'b0;
  logic         dma_req      = 1'b0;
  logic [W-1:0] dma_addr     = '0;
  logic [W-1:0] dma_wdata    = '0;
  logic         dma_write_en = 1'b0;
  logic         cpu_enable;
  logic         dma_grant;
  logic         dma_rvalid;
  logic [W-1:0] dma_rdata;
  logic [W-1:0] bus_addr;
  logic [W-1:0] bus_data_out;
  logic         bus_write_en;
  logic [W-1:0] bus_data_in;
  logic [1:0]   dbg_state;

  // Slave side: read-only memory image answering on the shared bus.
  logic [W-1:0] mem [256];
  assign bus_data_in = mem[int'(bus_addr)];

  reflet_bus_arbiter #(
    .wordsize  (W),
    .max_burst (MAXB),
    .cpu_min   (CMIN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_write_en (cpu_write_en),
    .cpu_enable   (cpu_enable),
    .dma_req      (dma_req),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .dma_write_en (dma_write_en),
    .dma_grant    (dma_grant),
    .dma_rvalid   (dma_rvalid),
    .dma_rdata    (dma_rdata),
    .bus_addr     (bus_addr),
    .bus_data_out (bus_data_out),
    .bus_write_en (bus_write_en),
    .bus_data_in  (bus_data_in),
    .dbg_state    (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks who owns the bus, how many CPU cycles have elapsed since the
  // last burst (capped at CMIN) and how many transfers the burst has done.
  typedef enum int {OWN_CPU, OWN_PARK, OWN_DMA, OWN_BACK} owner_e;

  owner_e       m_owner;
  int           m_share;
  int           m_xfers;
  logic         m_rvalid;
  logic [W-1:0] m_rdata;

  typedef struct {
    logic         cpu_en;
    logic         grant;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] data;
    logic         chk_ad;
    logic         rvalid;
    logic [W-1:0] rdata;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] rd_q[$];

  int drv_cyc = 0;
  int mon_cyc = 0;

  task automatic model_reset();
    m_owner  = OWN_CPU;
    m_share  = CMIN;
    m_xfers  = 0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    rd_q.delete();
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.cpu_en = (m_owner == OWN_CPU);
    e.grant  = (m_owner == OWN_DMA);
    e.rvalid = m_rvalid;
    e.rdata  = m_rdata;
    e.chk_ad = 1'b1;
    e.we     = 1'b0;
    e.addr   = cpu_addr;
    e.data   = cpu_data_out;
    case (m_owner)
      OWN_CPU:  e.we = cpu_write_en;
      OWN_PARK: e.data = '0;
      OWN_DMA: begin
        e.addr = dma_addr;
        e.data = dma_wdata;
        e.we   = dma_write_en & dma_req;
      end
      default:  e.chk_ad = 1'b0;
    endcase
    return e;
  endfunction

  // Advance the model across one clock edge using the inputs held this cycle.
  task automatic model_step();
    logic rd;
    rd = (m_owner == OWN_DMA) && dma_req && !dma_write_en;
    m_rvalid = rd;
    if (rd) begin
      m_rdata = mem[int'(dma_addr)];
      rd_q.push_back(mem[int'(dma_addr)]);
    end
    case (m_owner)
      OWN_CPU: begin
        if (dma_req && m_share == CMIN) m_owner = OWN_PARK;
        if (m_share < CMIN) m_share++;
      end
      OWN_PARK: begin
        m_owner = OWN_DMA;
        m_xfers = 0;
      end
      OWN_DMA: begin
        if (!dma_req) begin
          m_owner = OWN_BACK;
        end else begin
          m_xfers++;
          if (m_xfers == MAXB) m_owner = OWN_BACK;
        end
      end
      default: begin
        m_owner = OWN_CPU;
        m_share = 0;
      end
    endcase
  endtask

  // ---------------- driver ----------------
  // Entered and left at posedge+1.
  task automatic drive(input logic req, input logic [W-1:0] da, input logic [W-1:0] dw,
                       input logic dwe, input logic [W-1:0] ca, input logic [W-1:0] cd,
                       input logic cwe);
    dma_req      = req;
    dma_addr     = da;
    dma_wdata    = dw;
    dma_write_en = dwe;
    cpu_addr     = ca;
    cpu_data_out = cd;
    cpu_write_en = cwe;
    exp_q.push_back(expect_now());
    drv_cyc++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, W'($urandom), W'($urandom), 1'b0, W'($urandom), W'($urandom), 1'b0);
    end
  endtask

  // ---------------- monitor ----------------
  int cpu_off     = 0;
  int xfer_cnt    = 0;
  int wr90_cnt    = 0;
  int frozen_we   = 0;
  int run_len     = 0;
  int max_run     = 0;
  int first_grant = -1;
  logic arm_grant = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cpu_enable", cpu_enable, e.cpu_en);
      check("dma_grant", dma_grant, e.grant);
      check("bus_write_en", bus_write_en, e.we);
      check("dma_rvalid", dma_rvalid, e.rvalid);
      check("dma_rdata", dma_rdata, e.rdata);
      if (e.chk_ad) begin
        check("bus_addr", bus_addr, e.addr);
        check("bus_data_out", bus_data_out, e.data);
      end
      if (!cpu_enable) cpu_off++;
      if (dma_grant && dma_req) xfer_cnt++;
      if (bus_write_en && bus_addr == 8'h90 && bus_data_out == 8'h5A) wr90_cnt++;
      if (bus_write_en && !cpu_enable && !dma_grant) frozen_we++;
      if (dma_grant) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (arm_grant && dma_grant) begin
        first_grant = mon_cyc;
        arm_grant   = 1'b0;
      end
      mon_cyc++;
    end
    if (reset && dma_rvalid) begin
      if (rd_q.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
      else check("rdata_scoreboard", dma_rdata, rd_q.pop_front());
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int req_idx;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
    mem[8'h85] = 8'hC3;

    // Reset values, checked while reset is held low.
    reset    = 1'b0;
    cpu_addr = 8'h42;
    #12;
    check("rst_cpu_enable", cpu_enable, 1'b1);
    check("rst_dma_grant", dma_grant, 1'b0);
    check("rst_dma_rvalid", dma_rvalid, 1'b0);
    check("rst_dma_rdata", dma_rdata, 8'h00);
    check("rst_bus_addr", bus_addr, 8'h42);
    #10;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    idle(3);

    // Single DMA write.
    arm_grant = 1'b1;
    req_idx   = drv_cyc;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h90, 8'h5A, 1'b1, 8'h11, 8'h22, 1'b0);
    idle(10);
    check("write_grant_latency", 32'(first_grant - req_idx), 32'd2);
    check("write_count", wr90_cnt, 1);

    // DMA read with a CPU write pending at request time.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h85, 8'h00, 1'b0, 8'h33, 8'h44, 1'b1);
    idle(10);
    check("read_hold", dma_rdata, 8'hC3);

    // Burst limit with dma_req held high.
    xfer_cnt = 0;
    cpu_off  = 0;
    max_run  = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'b1, W'($urandom), W'($urandom),
            1'($urandom_range(0, 1)));
    end
    idle(10);
    check("burst_transfers", xfer_cnt, 7);
    check("burst_cpu_off", cpu_off, 12);
    check("burst_max_run", max_run, MAXB);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
            1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
            1'($urandom_range(0, 1)));
    end
    idle(10);

    // Reset in the middle of a burst.
    n = 0;
    while (m_owner != OWN_DMA && n < 20) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'b1, 8'h66, 8'h77, 1'b1);
      n++;
    end
    check("grant_before_reset", dma_grant, 1'b1);
    #2;
    dma_req = 1'b0;
    reset   = 1'b0;
    exp_q.delete();
    drv_cyc = mon_cyc;
    #1;
    check("midrst_dma_grant", dma_grant, 1'b0);
    check("midrst_cpu_enable", cpu_enable, 1'b1);
    check("midrst_bus_addr", bus_addr, 8'h66);
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    arm_grant = 1'b1;
    req_idx   = drv_cyc;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h12, 8'h34, 1'b1, 8'h00, 8'h00, 1'b0);
    idle(10);
    check("post_reset_grant_latency", 32'(first_grant - req_idx), 32'd2);

    // Wrap-up.
    @(negedge clk);
    #1;
    check("frozen_cpu_writes", frozen_we, 0);
    check("exp_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
